tt_um_monishvr_fifo_param: RTL and testbench
============================================

// Module: tt_um_monishvr_fifo_param
// PURPOSE
//  Parametrised synchronous FIFO; next generation of the 4-bit TT FIFO.
//  Configurable width/depth, programmable almost-full/almost-empty thresholds,
//  occupancy count, sticky overflow/underflow flags, flush, and selectable
//  read mode: registered or first-word-fall-through (FWFT).
//  Core block; the TT pin wrapper maps it onto ui_in/uo_out/uio.
// PARAMETERS
//  DATA_W    4  data word width in bits, >=1
//  DEPTH     8  number of entries, >=2 (need not be a power of two)
//  AF_LEVEL  6  almost_full asserted when count >= AF_LEVEL (1..DEPTH)
//  AE_LEVEL  2  almost_empty asserted when count <= AE_LEVEL (0..DEPTH-1)
//  FWFT      0  0 = registered read (1-cycle latency); 1 = fall-through head
// PORTS
//  clk           in   1         single clock, rising edge
//  rst_n         in   1         asynchronous reset, ACTIVE-HIGH despite name
//  flush         in   1         synchronous clear of contents and flags
//  wr_en         in   1         write request
//  wr_data       in   DATA_W    write data
//  rd_en         in   1         read request (FWFT: pop/acknowledge head)
//  rd_data       out  DATA_W    read data
//  rd_valid      out  1         rd_data holds a valid word
//  full          out  1         count == DEPTH
//  empty         out  1         count == 0
//  almost_full   out  1         count >= AF_LEVEL
//  almost_empty  out  1         count <= AE_LEVEL
//  count         out  CNT_W     occupancy, CNT_W = $clog2(DEPTH+1)
//  overflow      out  1         sticky: write rejected because full
//  underflow     out  1         sticky: read rejected because empty
// BEHAVIOUR
//  - Reset (rst_n=1, async assert, sync release): wr_ptr=rd_ptr=0, count=0,
//    empty=1, almost_empty=1, full=0, almost_full=0, rd_data=0,
//    rd_valid=0, overflow=underflow=0. Memory contents not reset.
//  - Reset mid-operation discards all stored words; no partial write.
//  - wr_acc = wr_en & (~full | rd_acc); rd_acc = rd_en & ~empty.
//  - Full + wr_en + rd_en: both accepted, count unchanged.
//  - Empty + wr_en + rd_en: write accepted, read rejected, underflow set.
//  - wr_en & ~wr_acc sets overflow; rd_en & empty sets underflow; both sticky
//    until reset or flush. Rejected ops change no pointer or data.
//  - Pointers increment on accept; wrap DEPTH-1 -> 0 (explicit compare, no
//    power-of-two masking). count += wr_acc - rd_acc; all flags derive
//    from the registered count (registered outputs, no comb. paths from inputs).
//  - FWFT=0: on rd_acc at edge N, rd_data = mem[rd_ptr] and rd_valid=1 after
//    edge N; rd_valid=0 after any edge without rd_acc; rd_data holds value.
//  - FWFT=1: rd_data = mem[rd_ptr] whenever ~empty, rd_valid = ~empty; a
//    written word is visible one cycle after its write edge; rd_en pops.
//  - flush: highest priority after reset; same next state as reset; wr_en /
//    rd_en in that cycle ignored, no flag set.
//  - Write-before-read not bypassed: word written at edge N readable from N+1.
// STRUCTURE
//  - fifo_pkg: CNT_W/PTR_W helper functions (clog2), FWFT mode constants.
//  - Sub-module fifo_ram: DEPTH x DATA_W register array, 1 write port,
//    1 async read port; control, pointers, flags stay in this module.
// TESTING  (DATA_W=4, DEPTH=4, AF=3, AE=1 unless stated)
//  1 Reset: assert rst_n mid-burst -> empty=1, count=0, flags 0, rd_valid=0.
//  2 Write 0xA,0xC,0x3,0x5 -> full=1 after 4th edge, almost_full from 3rd;
//    5th write 0x9 -> overflow=1, count=4; reads return A,C,3,5 in order.
//  3 Wrap: 10 alternating write/read pairs, data i -> every read equals
//    write data, pointers wrap, count stays <=1, no flags.
//  4 Full + wr_en+rd_en same cycle with 0x7 -> head popped, 0x7 stored,
//    count=4, overflow=0; empty + both -> underflow=1, count=1.
//  5 FWFT=1: write 0xB into empty -> rd_data=0xB, rd_valid=1 next cycle
//    without rd_en; rd_en pops, empty=1 next cycle. FWFT=0: 1-cycle latency.
//  6 flush while count=3, overflow=1, with wr_en=1 -> count=0, empty=1,
//    overflow=0, written word discarded. Repeat with DEPTH=5 (non-pow2).

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared width helpers and read-mode constants for the parametrised FIFO
package fifo_pkg;

    localparam int FWFT_OFF = 0;
    localparam int FWFT_ON  = 1;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/fifo_ram.sv
// rtl/fifo_ram.sv - DEPTH x DATA_W register array, one write port, one asynchronous read port
module fifo_ram #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8,
    parameter int PTR_W  = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [PTR_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [PTR_W-1:0]  raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/tt_um_monishvr_fifo_param.sv
// rtl/tt_um_monishvr_fifo_param.sv - synchronous FIFO with thresholds, sticky error flags, flush and FWFT option
module tt_um_monishvr_fifo_param
    import fifo_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = 6,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = FWFT_OFF,
    localparam int CNT_W   = cnt_width(DEPTH),
    localparam int PTR_W   = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [CNT_W-1:0]  count,
    output logic              overflow,
    output logic              underflow
);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d, underflow_q, underflow_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d, ram_rdata;
    logic              rd_valid_q, rd_valid_d;
    logic              empty_w, full_w, wr_acc, rd_acc;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_w = (count_q == '0);
    assign full_w  = (count_q == CNT_W'(DEPTH));
    assign rd_acc  = rd_en & ~empty_w & ~flush;
    assign wr_acc  = wr_en & (~full_w | rd_acc) & ~flush;

    fifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (ram_rdata)
    );

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            rd_data_d   = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (rd_acc) begin
                rd_ptr_d   = ptr_inc(rd_ptr_q);
                rd_data_d  = ram_rdata;
                rd_valid_d = 1'b1;
            end
            count_d = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
            if (wr_en && !wr_acc) begin
                overflow_d = 1'b1;
            end
            if (rd_en && empty_w) begin
                underflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
        end
    end

    assign full         = full_w;
    assign empty        = empty_w;
    assign almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    if (FWFT == FWFT_ON) begin : g_fwft
        assign rd_data  = empty_w ? '0 : ram_rdata;
        assign rd_valid = ~empty_w;
    end else begin : g_reg
        assign rd_data  = rd_data_q;
        assign rd_valid = rd_valid_q;
    end

endmodule

// File: tb/tb_tt_um_monishvr_fifo_param.sv
// tb/tb_tt_um_monishvr_fifo_param.sv - scoreboard bench: registered DEPTH=4, FWFT DEPTH=4, registered DEPTH=5
module tb_tt_um_monishvr_fifo_param;

    logic            clk;
    logic            rst;
    logic [2:0]      flush, wr_en, rd_en;
    logic [2:0][3:0] wr_data, rd_data;
    logic [2:0]      rd_valid, full, empty, af, ae, ovf, udf;
    logic [2:0][2:0] count;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q0[$], exp_q1[$], exp_q2[$];

    tt_um_monishvr_fifo_param #(.DATA_W(4), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_reg4 (
        .clk(clk), .rst_n(rst), .flush(flush[0]), .wr_en(wr_en[0]), .wr_data(wr_data[0]),
        .rd_en(rd_en[0]), .rd_data(rd_data[0]), .rd_valid(rd_valid[0]), .full(full[0]),
        .empty(empty[0]), .almost_full(af[0]), .almost_empty(ae[0]), .count(count[0]),
        .overflow(ovf[0]), .underflow(udf[0]));

    tt_um_monishvr_fifo_param #(.DATA_W(4), .DEPTH(4), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)) u_fwft4 (
        .clk(clk), .rst_n(rst), .flush(flush[1]), .wr_en(wr_en[1]), .wr_data(wr_data[1]),
        .rd_en(rd_en[1]), .rd_data(rd_data[1]), .rd_valid(rd_valid[1]), .full(full[1]),
        .empty(empty[1]), .almost_full(af[1]), .almost_empty(ae[1]), .count(count[1]),
        .overflow(ovf[1]), .underflow(udf[1]));

    tt_um_monishvr_fifo_param #(.DATA_W(4), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(0)) u_reg5 (
        .clk(clk), .rst_n(rst), .flush(flush[2]), .wr_en(wr_en[2]), .wr_data(wr_data[2]),
        .rd_en(rd_en[2]), .rd_data(rd_data[2]), .rd_valid(rd_valid[2]), .full(full[2]),
        .empty(empty[2]), .almost_full(af[2]), .almost_empty(ae[2]), .count(count[2]),
        .overflow(ovf[2]), .underflow(udf[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_st(input int k, input string tag, input int cnt, input bit e, input bit f,
                          input bit a_f, input bit a_e, input bit ov, input bit uf);
        chk({tag, "_count"}, int'(count[k]), cnt);
        chk({tag, "_empty"}, int'(empty[k]), int'(e));
        chk({tag, "_full"}, int'(full[k]), int'(f));
        chk({tag, "_afull"}, int'(af[k]), int'(a_f));
        chk({tag, "_aempty"}, int'(ae[k]), int'(a_e));
        chk({tag, "_ovf"}, int'(ovf[k]), int'(ov));
        chk({tag, "_udf"}, int'(udf[k]), int'(uf));
    endtask

    task automatic push(input int k, input logic [3:0] d);
        case (k)
            0: exp_q0.push_back(d);
            1: exp_q1.push_back(d);
            default: exp_q2.push_back(d);
        endcase
    endtask

    task automatic pop_cmp(input int k, input logic [3:0] act);
        logic [3:0] e;
        int sz;
        case (k)
            0: sz = exp_q0.size();
            1: sz = exp_q1.size();
            default: sz = exp_q2.size();
        endcase
        if (sz == 0) begin
            chk($sformatf("sb%0d_unexpected", k), int'(act), -1);
        end else begin
            case (k)
                0: e = exp_q0.pop_front();
                1: e = exp_q1.pop_front();
                default: e = exp_q2.pop_front();
            endcase
            chk($sformatf("sb%0d_rd_data", k), int'(act), int'(e));
        end
    endtask

    // Monitor: registered instances present a word while rd_valid; FWFT presents the head on pop.
    always @(negedge clk) begin
        if (!rst) begin
            if (rd_valid[0]) pop_cmp(0, rd_data[0]);
            if (rd_valid[1] && rd_en[1]) pop_cmp(1, rd_data[1]);
            if (rd_valid[2]) pop_cmp(2, rd_data[2]);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input int k, input bit we, input logic [3:0] wd, input bit re, input bit fl);
        wr_en[k] = we; wr_data[k] = wd; rd_en[k] = re; flush[k] = fl;
        cyc();
        wr_en[k] = 1'b0; rd_en[k] = 1'b0; flush[k] = 1'b0;
    endtask

    task automatic wr(input int k, input logic [3:0] d);
        op(k, 1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic rd(input int k, input logic [3:0] exp);
        push(k, exp);
        op(k, 1'b0, 4'h0, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        op(0, 1'b0, 4'h0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = '0; wr_en = '0; rd_en = '0; wr_data = '0;
        cyc(); cyc();
        rst = 1'b0;
        chk_st(0, "rst0", 0, 1, 0, 0, 1, 0, 0);
        chk("rst0_rd_valid", int'(rd_valid[0]), 0);
        chk("rst0_rd_data", int'(rd_data[0]), 0);
        chk("rst1_rd_valid", int'(rd_valid[1]), 0);
        chk("rst1_rd_data", int'(rd_data[1]), 0);

        // FWFT head visibility and pop
        wr(1, 4'hB);
        chk("fwft_valid", int'(rd_valid[1]), 1);
        chk("fwft_data", int'(rd_data[1]), 'hB);
        rd(1, 4'hB);
        chk("fwft_empty", int'(empty[1]), 1);
        chk("fwft_valid_after_pop", int'(rd_valid[1]), 0);
        wr(1, 4'h1); wr(1, 4'h2);
        rd(1, 4'h1); rd(1, 4'h2);
        chk_st(1, "fwft_end", 0, 1, 0, 0, 1, 0, 0);

        // Non-power-of-two depth: fill, overflow, flush, wrap
        for (int i = 1; i <= 4; i++) wr(2, 4'(i));
        chk_st(2, "d5_four", 4, 0, 0, 1, 0, 0, 0);
        wr(2, 4'h5);
        chk_st(2, "d5_full", 5, 0, 1, 1, 0, 0, 0);
        wr(2, 4'h6);
        chk_st(2, "d5_ovf", 5, 0, 1, 1, 0, 1, 0);
        rd(2, 4'h1);
        op(2, 1'b1, 4'hF, 1'b0, 1'b1);
        chk_st(2, "d5_flush", 0, 1, 0, 0, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            wr(2, 4'(i * 3));
            chk("d5_wrap_cnt1", int'(count[2]), 1);
            rd(2, 4'(i * 3));
        end
        chk_st(2, "d5_wrap_end", 0, 1, 0, 0, 1, 0, 0);

        // Fill, thresholds, overflow, in-order drain, underflow
        wr(0, 4'hA);
        chk_st(0, "w1", 1, 0, 0, 0, 1, 0, 0);
        chk("reg_no_fall_through", int'(rd_valid[0]), 0);
        wr(0, 4'hC);
        chk_st(0, "w2", 2, 0, 0, 0, 0, 0, 0);
        wr(0, 4'h3);
        chk_st(0, "w3", 3, 0, 0, 1, 0, 0, 0);
        wr(0, 4'h5);
        chk_st(0, "w4", 4, 0, 1, 1, 0, 0, 0);
        wr(0, 4'h9);
        chk_st(0, "w5_ovf", 4, 0, 1, 1, 0, 1, 0);
        rd(0, 4'hA); rd(0, 4'hC); rd(0, 4'h3); rd(0, 4'h5);
        chk_st(0, "drained", 0, 1, 0, 0, 1, 1, 0);
        chk("reg_rd_hold_valid", int'(rd_valid[0]), 1);
        op(0, 1'b0, 4'h0, 1'b1, 1'b0);
        chk_st(0, "udf", 0, 1, 0, 0, 1, 1, 1);
        chk("reg_rd_data_hold", int'(rd_data[0]), 'h5);
        chk("reg_rd_valid_drop", int'(rd_valid[0]), 0);

        // Reset mid-burst with a write pending on the reset edge
        wr(0, 4'h1);
        wr_en[0] = 1'b1; wr_data[0] = 4'h2;
        rst = 1'b1;
        cyc();
        rst = 1'b0; wr_en[0] = 1'b0;
        chk_st(0, "mid_rst", 0, 1, 0, 0, 1, 0, 0);
        chk("mid_rst_rd_valid", int'(rd_valid[0]), 0);

        // Wrap with alternating pairs
        for (int i = 0; i < 10; i++) begin
            wr(0, 4'(i));
            chk("wrap_cnt1", int'(count[0]), 1);
            rd(0, 4'(i));
            chk("wrap_cnt0", int'(count[0]), 0);
        end
        chk_st(0, "wrap_end", 0, 1, 0, 0, 1, 0, 0);

        // Simultaneous write/read at full and at empty
        for (int i = 1; i <= 4; i++) wr(0, 4'(i));
        push(0, 4'h1);
        op(0, 1'b1, 4'h7, 1'b1, 1'b0);
        chk_st(0, "full_both", 4, 0, 1, 1, 0, 0, 0);
        rd(0, 4'h2); rd(0, 4'h3); rd(0, 4'h4); rd(0, 4'h7);
        op(0, 1'b1, 4'h6, 1'b1, 1'b0);
        chk_st(0, "empty_both", 1, 0, 0, 0, 1, 0, 1);
        rd(0, 4'h6);
        do_reset();

        // Flush with count=3, overflow set, and a write in the flush cycle
        for (int i = 1; i <= 5; i++) wr(0, 4'(i));
        rd(0, 4'h1);
        chk_st(0, "pre_flush", 3, 0, 0, 1, 0, 1, 0);
        op(0, 1'b1, 4'hF, 1'b0, 1'b1);
        chk_st(0, "flush", 0, 1, 0, 0, 1, 0, 0);
        wr(0, 4'h8);
        chk("post_flush_cnt", int'(count[0]), 1);
        rd(0, 4'h8);
        cyc(); cyc();

        chk("sb0_drained", exp_q0.size(), 0);
        chk("sb1_drained", exp_q1.size(), 0);
        chk("sb2_drained", exp_q2.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
